norm_chan_pipe: RTL and testbench

- Parametrised next-generation normalization stage that sits between the systolic matmul output and the pooling/activation path.
- Each lane applies y = (x - mean[lane]) * inv_var[lane] in signed fixed point, using per-lane (per-channel) mean and inverse-variance registers.
- Rounding is selectable and results saturate to the output width.
- Data moves on a valid/ready handshake with full backpressure, and the block counts columns to raise done_norm at the end of a pass.

---
 rtl/norm_chan_pipe.sv | 185 ++++++++++++++++++
 tb/tb_norm_chan_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_chan_pipe.sv
// Per-lane normalization stage: y = (x - mean[lane]) * inv_var[lane] in signed
// fixed point, with selectable rounding, output saturation, a two-stage
// valid/ready pipeline and a per-pass column counter that pulses done_norm.
//
// state | meaning
// IDLE  | waiting for the first column of a pass; parameter loads accepted here
// RUN   | accepting columns until NUM_COLS have been taken
// DRAIN | input closed, waiting for the remaining columns to leave the pipe
// DONE  | one-cycle done_norm pulse, counters cleared on exit
module norm_chan_pipe #(
  parameter int DESIGN_SIZE = 32,
  parameter int DWIDTH      = 8,
  parameter int FRAC_BITS   = 3,
  parameter int NUM_COLS    = 32,
  parameter int CNT_W       = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_norm,
  input  logic                          round_mode,
  input  logic                          params_load,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] mean_vec,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inv_var_vec,
  input  logic [DESIGN_SIZE-1:0]        validity_mask,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          done_norm,
  output logic                          sat_flag
);

  localparam int DW_ALL = DESIGN_SIZE * DWIDTH;
  localparam int DW1    = DWIDTH + 1;
  localparam int PW     = 2 * DWIDTH + 1;
  localparam logic signed [PW-1:0] HALF    = PW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (DWIDTH - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (DWIDTH - 1)));
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(NUM_COLS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        in_count, out_count, in_cnt_nxt, out_cnt_nxt;
  logic [DW_ALL-1:0]       mean_q, inv_q;

  logic                    s1_valid, s1_round;
  logic [DESIGN_SIZE-1:0]  s1_mask;
  logic signed [DWIDTH:0]  s1_d   [DESIGN_SIZE];
  logic signed [DWIDTH-1:0] s1_inv [DESIGN_SIZE];
  logic signed [DWIDTH:0]  d_nxt  [DESIGN_SIZE];

  logic                    s2_valid;
  logic [DW_ALL-1:0]       s2_data, s2_nxt;
  logic                    sat_any, sat_q;

  logic signed [PW-1:0]    prod, bias, shifted;
  logic [DWIDTH-1:0]       lane;

  logic                    stall, run_ready, accept, out_fire;

  assign stall       = s2_valid && !out_ready;
  assign run_ready   = (state == IDLE || state == RUN) && (in_count < LAST) && !(s1_valid && stall);
  assign accept      = enable_norm && !reset && in_valid && run_ready;
  assign out_fire    = enable_norm && s2_valid && out_ready;
  assign in_cnt_nxt  = in_count + CNT_W'(accept);
  assign out_cnt_nxt = out_count + CNT_W'(out_fire);

  assign in_ready  = !reset && (enable_norm ? run_ready : out_ready);
  assign out_valid = !reset && (enable_norm ? s2_valid : in_valid);
  assign out_data  = enable_norm ? s2_data : inp_data;
  assign done_norm = !reset && enable_norm && (state == DONE);
  assign sat_flag  = !reset && sat_q;

  // S1 operand: mean-subtracted value for normalized lanes, raw x for masked lanes
  always_comb begin
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      if (validity_mask[i])
        d_nxt[i] = DW1'(signed'(inp_data[i*DWIDTH +: DWIDTH])) - DW1'(signed'(mean_q[i*DWIDTH +: DWIDTH]));
      else
        d_nxt[i] = DW1'(signed'(inp_data[i*DWIDTH +: DWIDTH]));
    end
  end

  // S2 datapath: scale, round or floor, then clamp to the output range
  always_comb begin
    s2_nxt  = '0;
    sat_any = 1'b0;
    prod    = '0;
    bias    = '0;
    shifted = '0;
    lane    = '0;
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      prod    = PW'(s1_d[i]) * PW'(s1_inv[i]);
      bias    = s1_round ? HALF : '0;
      shifted = (prod + bias) >>> FRAC_BITS;
      if (!s1_mask[i]) begin
        lane = s1_d[i][DWIDTH-1:0];
      end else if (shifted > SAT_MAX) begin
        lane    = SAT_MAX[DWIDTH-1:0];
        sat_any = 1'b1;
      end else if (shifted < SAT_MIN) begin
        lane    = SAT_MIN[DWIDTH-1:0];
        sat_any = 1'b1;
      end else begin
        lane = shifted[DWIDTH-1:0];
      end
      s2_nxt[i*DWIDTH +: DWIDTH] = lane;
    end
  end

  // Per-lane parameters only change between passes
  always_ff @(posedge clk) begin
    if (reset) begin
      mean_q <= '0;
      inv_q  <= '0;
    end else if (params_load && state == IDLE) begin
      mean_q <= mean_vec;
      inv_q  <= inv_var_vec;
    end
  end

  // Two-stage pipe; an empty S1 may refill while S2 is held by backpressure
  always_ff @(posedge clk) begin
    if (reset || !enable_norm) begin
      s1_valid <= 1'b0;
      s1_round <= 1'b0;
      s1_mask  <= '0;
      s1_d     <= '{default: '0};
      s1_inv   <= '{default: '0};
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (!(s1_valid && stall)) begin
        s1_valid <= accept;
        if (accept) begin
          s1_round <= round_mode;
          s1_mask  <= validity_mask;
          s1_d     <= d_nxt;
          for (int i = 0; i < DESIGN_SIZE; i++)
            s1_inv[i] <= inv_q[i*DWIDTH +: DWIDTH];
        end
      end
      if (!stall) begin
        s2_valid <= s1_valid;
        if (s1_valid)
          s2_data <= s2_nxt;
      end
    end
  end

  // Pass sequencing, column counters and the sticky saturation flag
  always_ff @(posedge clk) begin
    if (reset || !enable_norm) begin
      state     <= IDLE;
      in_count  <= '0;
      out_count <= '0;
      sat_q     <= 1'b0;
    end else begin
      in_count  <= in_cnt_nxt;
      out_count <= out_cnt_nxt;
      if (state == IDLE && accept)
        sat_q <= 1'b0;
      else if (!stall && s1_valid && sat_any)
        sat_q <= 1'b1;
      case (state)
        IDLE:  if (accept) state <= (in_cnt_nxt == LAST) ? DRAIN : RUN;
        RUN: begin
          if (out_cnt_nxt == LAST)     state <= DONE;
          else if (in_cnt_nxt == LAST) state <= DRAIN;
        end
        DRAIN: if (out_cnt_nxt == LAST) state <= DONE;
        DONE: begin
          state     <= IDLE;
          in_count  <= '0;
          out_count <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_chan_pipe.sv
// Directed bench for norm_chan_pipe: full passes with hand-computed columns,
// backpressure, mid-pass reset and bypass mode.
module tb_norm_chan_pipe;

  localparam int DS     = 32;
  localparam int DW     = 8;
  localparam int NC     = 32;
  localparam int DATA_W = DS * DW;

  logic              clk = 1'b0;
  logic              reset, enable_norm, round_mode, params_load;
  logic [DATA_W-1:0] mean_vec, inv_var_vec, inp_data, out_data;
  logic [DS-1:0]     validity_mask;
  logic              in_valid, in_ready, out_valid, out_ready, done_norm, sat_flag;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] col_x   [NC];
  logic              col_mode[NC];
  logic [DS-1:0]     col_mask[NC];
  logic [DATA_W-1:0] exp_col [NC];
  logic [DATA_W-1:0] got     [NC];
  logic [DATA_W-1:0] tmp_m, tmp_x, tmp_e;
  int                acc_cnt, stray;

  norm_chan_pipe dut (
    .clk(clk), .reset(reset), .enable_norm(enable_norm), .round_mode(round_mode),
    .params_load(params_load), .mean_vec(mean_vec), .inv_var_vec(inv_var_vec),
    .validity_mask(validity_mask), .in_valid(in_valid), .in_ready(in_ready),
    .inp_data(inp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .done_norm(done_norm), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rep(input logic [7:0] b);
    rep = {DS{b}};
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] ex);
    n_assert++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic ex);
    n_assert++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, ex);
    end
  endtask

  task automatic load_params(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] iv);
    @(negedge clk);
    mean_vec    = m;
    inv_var_vec = iv;
    params_load = 1'b1;
    @(negedge clk);
    params_load = 1'b0;
  endtask

  // Streams the NC columns in col_* and checks the pass against exp_col.
  task automatic run_pass(input string tag, input bit rand_rdy, input bit pl_in_run, input bit chk_lat);
    int sent, recv, done_cnt, bad_done, bad_acc, bad_hold, last_out, first_acc, first_out, idx;
    logic hold_pend;
    logic [DATA_W-1:0] hold_data;
    sent = 0; recv = 0; done_cnt = 0; bad_done = 0; bad_acc = 0; bad_hold = 0;
    last_out = -10; first_acc = -1; first_out = -1; hold_pend = 1'b0; hold_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      idx           = (sent < NC) ? sent : NC - 1;
      in_valid      = (sent < NC) || (recv < NC);
      inp_data      = col_x[idx];
      round_mode    = col_mode[idx];
      validity_mask = col_mask[idx];
      out_ready     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      params_load   = pl_in_run && sent >= 1 && sent < NC;
      #1;
      if (hold_pend && !(out_valid === 1'b1 && out_data === hold_data)) bad_hold++;
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (done_norm) begin
        done_cnt++;
        if (cyc != last_out + 1) bad_done++;
      end
      if (in_valid && in_ready) begin
        if (sent >= NC) bad_acc++;
        else begin
          if (sent == 0) first_acc = cyc;
          sent++;
        end
      end
      if (out_valid && out_ready) begin
        if (recv < NC) got[recv] = out_data;
        if (recv == 0) first_out = cyc;
        recv++;
        last_out = cyc;
      end
    end
    params_load = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    chk({tag, " accepted"}, DATA_W'(sent), DATA_W'(NC));
    chk({tag, " outputs"}, DATA_W'(recv), DATA_W'(NC));
    chk({tag, " done pulses"}, DATA_W'(done_cnt), DATA_W'(1));
    chk({tag, " done timing"}, DATA_W'(bad_done), DATA_W'(0));
    chk({tag, " accept after full"}, DATA_W'(bad_acc), DATA_W'(0));
    chk({tag, " stall stability"}, DATA_W'(bad_hold), DATA_W'(0));
    if (chk_lat) chk({tag, " latency"}, DATA_W'(first_out - first_acc), DATA_W'(2));
    for (int k = 0; k < NC; k++)
      chk($sformatf("%s col%0d", tag, k), got[k], exp_col[k]);
  endtask

  initial begin
    reset = 1'b1; enable_norm = 1'b1; round_mode = 1'b0; params_load = 1'b0;
    mean_vec = '0; inv_var_vec = '0; validity_mask = '0; in_valid = 1'b1;
    inp_data = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_bit("reset out_valid", out_valid, 1'b0);
    chk_bit("reset in_ready", in_ready, 1'b0);
    chk_bit("reset done_norm", done_norm, 1'b0);
    chk_bit("reset sat_flag", sat_flag, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b0;

    // basic: (0x18-0x08)*1.5 = 0x18
    load_params(rep(8'h08), rep(8'h0C));
    for (int k = 0; k < NC; k++) begin
      col_x[k] = rep(8'h18); col_mode[k] = 1'b1; col_mask[k] = '1; exp_col[k] = rep(8'h18);
    end
    run_pass("basic", 1'b0, 1'b0, 1'b1);
    chk_bit("basic sat_flag", sat_flag, 1'b0);

    // rounding: 9*1.5 = 13.5, -9*1.5 = -13.5
    load_params('0, rep(8'h0C));
    for (int k = 0; k < NC; k++) begin
      col_mask[k] = '1;
      case (k % 4)
        0:       begin col_x[k] = rep(8'h09); col_mode[k] = 1'b1; exp_col[k] = rep(8'h0E); end
        1:       begin col_x[k] = rep(8'h09); col_mode[k] = 1'b0; exp_col[k] = rep(8'h0D); end
        2:       begin col_x[k] = rep(8'hF7); col_mode[k] = 1'b1; exp_col[k] = rep(8'hF3); end
        default: begin col_x[k] = rep(8'hF7); col_mode[k] = 1'b0; exp_col[k] = rep(8'hF2); end
      endcase
    end
    run_pass("round", 1'b0, 1'b0, 1'b0);
    chk_bit("round sat_flag", sat_flag, 1'b0);

    // only masked lanes would overflow: even lanes mean 0x80, odd lanes mean 0x7F
    for (int i = 0; i < DS; i++) begin
      tmp_m[i*DW +: DW] = (i % 2 == 0) ? 8'h80 : 8'h7F;
      tmp_e[i*DW +: DW] = (i % 2 == 0) ? 8'h10 : 8'h91;
    end
    load_params(tmp_m, rep(8'h08));
    for (int k = 0; k < NC; k++) begin
      col_x[k] = rep(8'h10); col_mode[k] = 1'b1;
      col_mask[k] = (k % 2 == 0) ? 32'h0000_0000 : 32'hAAAA_AAAA;
      exp_col[k]  = (k % 2 == 0) ? rep(8'h10) : tmp_e;
    end
    run_pass("maskonly", 1'b0, 1'b0, 1'b0);
    chk_bit("maskonly sat_flag", sat_flag, 1'b0);

    // saturation on normalized lanes, mixed mask, random backpressure
    for (int i = 0; i < DS; i++) begin
      tmp_x[i*DW +: DW] = (i % 2 == 0) ? 8'h7F : 8'h80;
      if (i < 16) tmp_e[i*DW +: DW] = (i % 2 == 0) ? 8'h7F : 8'h81;
      else        tmp_e[i*DW +: DW] = 8'h00;
    end
    for (int k = 0; k < NC; k++) begin
      col_mode[k] = 1'b1;
      col_x[k]    = (k % 2 == 0) ? tmp_x : '0;
      col_mask[k] = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      exp_col[k]  = (k % 2 == 0) ? tmp_x : tmp_e;
    end
    run_pass("sat", 1'b1, 1'b0, 1'b0);
    chk_bit("sat sat_flag", sat_flag, 1'b1);

    // per-lane mean, junk params presented with params_load during RUN
    for (int i = 0; i < DS; i++) begin
      tmp_m[i*DW +: DW] = 8'(i);
      tmp_e[i*DW +: DW] = 8'(32 - i);
    end
    load_params(tmp_m, rep(8'h08));
    mean_vec    = rep(8'h10);
    inv_var_vec = rep(8'h20);
    for (int k = 0; k < NC; k++) begin
      col_x[k] = rep(8'h20); col_mode[k] = 1'b1; col_mask[k] = '1; exp_col[k] = tmp_e;
    end
    run_pass("perlane", 1'b1, 1'b1, 1'b0);
    chk_bit("perlane sat_flag cleared", sat_flag, 1'b0);

    // reset after 10 accepted columns
    load_params(rep(8'h08), rep(8'h0C));
    acc_cnt = 0;
    for (int c = 0; c < 100 && acc_cnt < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; inp_data = rep(8'h18); round_mode = 1'b1;
      validity_mask = '1; out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) acc_cnt++;
    end
    chk("midreset accepted", DATA_W'(acc_cnt), DATA_W'(10));
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk_bit("midreset out_valid", out_valid, 1'b0);
    chk_bit("midreset in_ready", in_ready, 1'b0);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) stray++;
    end
    chk("midreset residual outputs", DATA_W'(stray), DATA_W'(0));
    load_params(rep(8'h08), rep(8'h0C));
    for (int k = 0; k < NC; k++) begin
      col_x[k] = rep(8'h18); col_mode[k] = 1'b1; col_mask[k] = '1; exp_col[k] = rep(8'h18);
    end
    run_pass("fresh", 1'b0, 1'b0, 1'b1);

    // bypass
    @(negedge clk);
    enable_norm = 1'b0;
    inp_data = rep(8'h5A); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bypass data 5A", out_data, rep(8'h5A));
    chk_bit("bypass out_valid 1", out_valid, 1'b1);
    chk_bit("bypass in_ready 1", in_ready, 1'b1);
    chk_bit("bypass done_norm", done_norm, 1'b0);
    @(negedge clk);
    inp_data = {16{16'hC381}}; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bypass data C381", out_data, {16{16'hC381}});
    chk_bit("bypass out_valid 0", out_valid, 1'b0);
    @(negedge clk);
    inp_data = rep(8'hE7); in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("bypass data E7", out_data, rep(8'hE7));
    chk_bit("bypass in_ready 0", in_ready, 1'b0);
    chk_bit("bypass sat_flag", sat_flag, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; enable_norm = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
